// File: rtl/nonce_tx_queue.sv
// Golden-nonce FIFO between the miner's ticket output and the serial TX handshake.
// Optional NONCE_QUEUE_DEDUP_EN drops a capture that repeats the last accepted nonce.
module nonce_tx_queue #(
  parameter int DEPTH       = 4,
  parameter int ADDR_BITS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 got_ticket,
  input  logic [31:0]          golden_nonce,
  input  logic                 flush,
  input  logic                 tx_busy,
  output logic                 tx_ready,
  output logic [31:0]          word,
  output logic                 new_nonce,
  output logic [ADDR_BITS:0]   queue_level,
  output logic [7:0]           overflow_count
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   syncPrev_q;
  logic [ADDR_BITS:0]     wrPtr_q, rdPtr_q;
  logic [31:0]            mem_q [DEPTH];
  logic [7:0]             overflowCnt_q;
  logic                   newNonce_q;
  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [31:0]            word_q, word_d;
  logic                   txReady_q, txReady_d;

  logic               capture, isDup, captureKept;
  logic [ADDR_BITS:0] level;
  logic               fifoFull, fifoEmpty, pop, pushOk, dropIt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      syncPrev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], got_ticket};
      syncPrev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign capture = sync_q[SYNC_STAGES-1] & ~syncPrev_q;

`ifdef NONCE_QUEUE_DEDUP_EN
  logic [31:0] lastNonce_q;
  logic        lastValid_q;

  assign isDup = lastValid_q && (golden_nonce == lastNonce_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastNonce_q <= '0;
      lastValid_q <= 1'b0;
    end else if (flush) begin
      lastValid_q <= 1'b0;
    end else if (capture && !isDup) begin
      lastNonce_q <= golden_nonce;
      lastValid_q <= 1'b1;
    end
  end
`else
  assign isDup = 1'b0;
`endif

  assign captureKept = capture & ~isDup;
  assign level       = wrPtr_q - rdPtr_q;
  assign fifoFull    = (level == (ADDR_BITS+1)'(DEPTH));
  assign fifoEmpty   = (level == '0);
  assign pop         = (state_q == IDLE) && !fifoEmpty && !tx_busy;
  // A pop frees the slot this same edge, so a full FIFO can still accept the push.
  assign pushOk      = captureKept && !flush && (!fifoFull || pop);
  assign dropIt      = captureKept && !flush && fifoFull && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      overflowCnt_q <= '0;
      newNonce_q    <= 1'b0;
    end else begin
      if (flush) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        wrPtr_q <= wrPtr_q + (ADDR_BITS+1)'(pushOk);
        rdPtr_q <= rdPtr_q + (ADDR_BITS+1)'(pop);
      end
      if (dropIt && overflowCnt_q != 8'hFF)
        overflowCnt_q <= overflowCnt_q + 8'd1;
      newNonce_q <= pushOk;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk)
      mem_q[wrPtr_q[ADDR_BITS-1:0]] <= golden_nonce;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      word_q    <= '0;
      txReady_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      word_q    <= word_d;
      txReady_q <= txReady_d;
    end
  end

  // The strobe is registered on the load edge so it coincides with the SEND state.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    word_d    = word_q;
    txReady_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          word_d    = mem_q[rdPtr_q[ADDR_BITS-1:0]];
          txReady_d = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy)
          state_d = WAIT_DONE;
        else if (timer_q == TW'(ACK_TIMEOUT - 1))
          state_d = IDLE;
        else
          timer_d = timer_q + TW'(1);
      end
      WAIT_DONE: begin
        if (!tx_busy)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready       = txReady_q;
  assign word           = word_q;
  assign new_nonce      = newNonce_q;
  assign queue_level    = level;
  assign overflow_count = overflowCnt_q;

endmodule
